pu_rr_scheduler: RTL and testbench

- Shares one processing_unit (16x16 multiplier, fixed-latency, strobe-only) between NUM_REQ requesters.
- Uses round-robin arbitration with a valid/ready handshake on each requester input.
- Issues the granted word to the unit through a registered issue stage.
- Tracks the requester index of every in-flight word in a tag pipeline, then routes each returning result to its owner.
- Sits between the requester streams and the processing_unit; the unit's CLK/RST are driven from the same CLK/RST.

---
 rtl/pu_rr_scheduler.sv | 105 ++++++++++
 tb/tb_pu_rr_scheduler.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pu_rr_scheduler.sv
// rtl/pu_rr_scheduler.sv - round-robin scheduler sharing one fixed-latency processing unit
// Grants one requester per cycle, issues its word, and routes the tagged result back to it.
module pu_rr_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DAT_W      = 32,
  parameter int RES_W      = 32,
  parameter int PU_LATENCY = 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       EN,
  input  logic [NUM_REQ-1:0]         I_STB,
  input  logic [NUM_REQ*DAT_W-1:0]   I_DAT,
  output logic [NUM_REQ-1:0]         I_RDY,
  output logic                       PU_I_STB,
  output logic [DAT_W-1:0]           PU_I_DAT,
  input  logic                       PU_O_STB,
  input  logic [RES_W-1:0]           PU_O_DAT,
  output logic [NUM_REQ-1:0]         O_STB,
  output logic [RES_W-1:0]           O_DAT,
  output logic                       ERR
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TAG_N = PU_LATENCY + 1;

  logic [IDX_W-1:0]   r_last;
  logic               r_pu_stb;
  logic [DAT_W-1:0]   r_pu_dat;
  logic [TAG_N-1:0]   r_tag_vld;
  logic [IDX_W-1:0]   r_tag_idx [TAG_N];
  logic [NUM_REQ-1:0] r_ostb;
  logic [RES_W-1:0]   r_odat;
  logic               r_err;

  logic               w_found;
  logic [IDX_W-1:0]   w_gnt;
  logic [NUM_REQ-1:0] w_rdy;
  logic               w_xfer;
  logic               w_al_vld;
  logic [IDX_W-1:0]   w_al_idx;

  // Search starts just after the last winner, so the last winner has lowest priority.
  always_comb begin
    int j;
    j       = 0;
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(r_last) + k) % NUM_REQ;
      if (!w_found && I_STB[j]) begin
        w_found = 1'b1;
        w_gnt   = IDX_W'(j);
      end
    end
  end

  always_comb begin
    w_rdy = '0;
    if (EN && !RST && w_found) w_rdy[w_gnt] = 1'b1;
  end

  assign w_xfer   = |w_rdy;
  assign w_al_vld = r_tag_vld[TAG_N-1];
  assign w_al_idx = r_tag_idx[TAG_N-1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_last    <= IDX_W'(NUM_REQ - 1);
      r_pu_stb  <= 1'b0;
      r_pu_dat  <= '0;
      r_tag_vld <= '0;
      r_ostb    <= '0;
      r_odat    <= '0;
      r_err     <= 1'b0;
    end else begin
      r_pu_stb  <= w_xfer;
      if (w_xfer) begin
        r_last   <= w_gnt;
        r_pu_dat <= I_DAT[w_gnt*DAT_W +: DAT_W];
      end
      r_tag_vld <= {r_tag_vld[TAG_N-2:0], w_xfer};
      r_ostb    <= '0;
      if (PU_O_STB && w_al_vld) begin
        r_ostb <= NUM_REQ'(1) << w_al_idx;
        r_odat <= PU_O_DAT;
      end
      // A result without a tag, or a tag without a result, means the unit latency is wrong.
      if (PU_O_STB != w_al_vld) r_err <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    r_tag_idx[0] <= w_gnt;
    for (int s = 1; s < TAG_N; s++) r_tag_idx[s] <= r_tag_idx[s-1];
  end

  assign I_RDY    = w_rdy;
  assign PU_I_STB = r_pu_stb;
  assign PU_I_DAT = r_pu_dat;
  assign O_STB    = r_ostb;
  assign O_DAT    = r_odat;
  assign ERR      = r_err;

endmodule

// File: tb/tb_pu_rr_scheduler.sv
// tb/tb_pu_rr_scheduler.sv - directed bench for pu_rr_scheduler with a 1-cycle multiplier model
module tb_pu_rr_scheduler;

  localparam logic [31:0] D [4] = '{32'h0003_0005, 32'h0002_0007, 32'h0010_0010, 32'hFFFF_FFFF};
  localparam logic [31:0] P [4] = '{32'h0000_000F, 32'h0000_000E, 32'h0000_0100, 32'hFFFE_0001};

  logic         CLK;
  logic         RST;
  logic         EN;
  logic [3:0]   I_STB;
  logic [127:0] I_DAT;
  logic [3:0]   I_RDY;
  logic         PU_I_STB;
  logic [31:0]  PU_I_DAT;
  logic         PU_O_STB;
  logic [31:0]  PU_O_DAT;
  logic [3:0]   O_STB;
  logic [31:0]  O_DAT;
  logic         ERR;

  logic         m_stb;
  logic [31:0]  m_dat;
  logic         inj;
  logic         sup;
  int           n_chk;
  int           n_err;

  pu_rr_scheduler #(.NUM_REQ(4), .DAT_W(32), .RES_W(32), .PU_LATENCY(1)) dut (
    .CLK(CLK), .RST(RST), .EN(EN),
    .I_STB(I_STB), .I_DAT(I_DAT), .I_RDY(I_RDY),
    .PU_I_STB(PU_I_STB), .PU_I_DAT(PU_I_DAT),
    .PU_O_STB(PU_O_STB), .PU_O_DAT(PU_O_DAT),
    .O_STB(O_STB), .O_DAT(O_DAT), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Processing unit: unsigned 16x16 multiply, one cycle latency, reset with the scheduler.
  always @(posedge CLK) begin
    if (RST) begin
      m_stb <= 1'b0;
      m_dat <= '0;
    end else begin
      m_stb <= PU_I_STB;
      m_dat <= 32'(PU_I_DAT[15:0]) * 32'(PU_I_DAT[31:16]);
    end
  end
  assign PU_O_STB = (m_stb & ~sup) | inj;
  assign PU_O_DAT = m_dat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int i);
    oh = 4'b0001 << i;
  endfunction

  initial begin
    n_chk = 0; n_err = 0;
    RST = 1'b1; EN = 1'b1; I_STB = 4'b1111; inj = 1'b0; sup = 1'b0;
    I_DAT = {D[3], D[2], D[1], D[0]};

    @(negedge CLK); #1;
    check("rst_rdy", 32'(I_RDY), 32'h0);
    check("rst_pu_stb", 32'(PU_I_STB), 32'h0);
    check("rst_pu_dat", PU_I_DAT, 32'h0);
    check("rst_ostb", 32'(O_STB), 32'h0);
    check("rst_odat", O_DAT, 32'h0);
    check("rst_err", 32'(ERR), 32'h0);

    // single word from requester 0
    @(negedge CLK); RST = 1'b0; I_STB = 4'b0001; #1;
    check("t1_rdy", 32'(I_RDY), 32'h1);
    @(negedge CLK); I_STB = 4'b0000; #1;
    check("t1_pu_stb", 32'(PU_I_STB), 32'h1);
    check("t1_pu_dat", PU_I_DAT, D[0]);
    check("t1_ostb_early", 32'(O_STB), 32'h0);
    @(negedge CLK); #1;
    check("t1_pu_stb_off", 32'(PU_I_STB), 32'h0);
    check("t1_ostb_t2", 32'(O_STB), 32'h0);
    @(negedge CLK); #1;
    check("t1_ostb", 32'(O_STB), 32'h1);
    check("t1_odat", O_DAT, P[0]);
    check("t1_err", 32'(ERR), 32'h0);
    @(negedge CLK); #1;
    check("t1_ostb_off", 32'(O_STB), 32'h0);
    check("t1_odat_hold", O_DAT, P[0]);

    // all four requesters from reset
    @(negedge CLK); RST = 1'b1; I_STB = 4'b1111;
    @(negedge CLK); RST = 1'b0;
    for (int c = 0; c < 11; c++) begin
      if (c > 0) @(negedge CLK);
      I_STB = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      check("rr_rdy", 32'(I_RDY), (c < 8) ? 32'(oh(c % 4)) : 32'h0);
      if (c >= 3) begin
        check("rr_ostb", 32'(O_STB), 32'(oh((c - 3) % 4)));
        check("rr_odat", O_DAT, P[(c - 3) % 4]);
      end
    end

    // fairness between requesters 1 and 3
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      I_STB = (c < 4) ? 4'b1010 : 4'b0000;
      #1;
      check("fair_rdy", 32'(I_RDY), (c < 4) ? ((c % 2 == 0) ? 32'h2 : 32'h8) : 32'h0);
      if (c >= 3 && c < 7) begin
        check("fair_ostb", 32'(O_STB), ((c - 3) % 2 == 0) ? 32'h2 : 32'h8);
        check("fair_odat", O_DAT, ((c - 3) % 2 == 0) ? P[1] : P[3]);
      end else begin
        check("fair_ostb_idle", 32'(O_STB), 32'h0);
      end
    end

    // EN low with everyone requesting; the in-flight word still drains
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      EN = !(c >= 1 && c <= 5);
      I_STB = (c == 0) ? 4'b0001 : (c <= 6) ? 4'b1111 : 4'b0000;
      #1;
      check("en_rdy", 32'(I_RDY), (c == 0) ? 32'h1 : (c == 6) ? 32'h2 : 32'h0);
      check("en_ostb", 32'(O_STB), (c == 3) ? 32'h1 : (c == 9) ? 32'h2 : 32'h0);
      if (c == 3) check("en_odat0", O_DAT, P[0]);
      if (c == 9) check("en_odat1", O_DAT, P[1]);
    end

    // result strobe with nothing in flight
    @(negedge CLK); inj = 1'b1; #1;
    check("inj_err_before", 32'(ERR), 32'h0);
    @(negedge CLK); inj = 1'b0; #1;
    check("inj_err", 32'(ERR), 32'h1);
    check("inj_ostb", 32'(O_STB), 32'h0);
    repeat (3) @(negedge CLK);
    #1;
    check("inj_err_sticky", 32'(ERR), 32'h1);

    // reset with two words in flight
    for (int c = 0; c < 7; c++) begin
      @(negedge CLK);
      RST   = (c == 2);
      I_STB = (c <= 2) ? 4'b0101 : (c == 3) ? 4'b1111 : 4'b0000;
      #1;
      if (c == 0) check("mr_rdy0", 32'(I_RDY), 32'h4);
      if (c == 1) check("mr_rdy1", 32'(I_RDY), 32'h1);
      if (c == 2) check("mr_rdy_rst", 32'(I_RDY), 32'h0);
      if (c == 3) begin
        check("mr_rdy_after", 32'(I_RDY), 32'h1);
        check("mr_err_clr", 32'(ERR), 32'h0);
        check("mr_pu_stb", 32'(PU_I_STB), 32'h0);
      end
      if (c >= 3) check("mr_ostb", 32'(O_STB), (c == 6) ? 32'h1 : 32'h0);
      if (c == 6) begin
        check("mr_odat", O_DAT, P[0]);
        check("mr_err", 32'(ERR), 32'h0);
      end
    end

    // tag arrives but the unit drops its result strobe
    @(negedge CLK); sup = 1'b1; I_STB = 4'b0001; #1;
    check("sup_rdy", 32'(I_RDY), 32'h1);
    @(negedge CLK); I_STB = 4'b0000;
    @(negedge CLK);
    @(negedge CLK); #1;
    check("sup_err", 32'(ERR), 32'h1);
    check("sup_ostb", 32'(O_STB), 32'h0);
    sup = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
